// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_arb_pkg;

  localparam int ADDR_W_DEF     = 5;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } own_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // True when any byte-address bit above the word-address field is set.
  function automatic logic addr_oor(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of fetch grants taken while a debug request waits.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX_V))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/imem_arbiter.sv
// Fetch-priority arbiter for the single-port iMEM with a debug starvation guard.
// Define IMEM_ARB_WRITE_EN to allow debug writes; otherwise the memory is ROM.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  input  logic              flush,
  output logic              f_gnt,
  output logic              f_hold,
  output logic              f_valid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic starve_at_max;
  logic f_oor, d_oor, d_bad;
  own_e owner_q, owner_d;
  logic f_kill_q, f_kill_d;
  logic f_oor_q, f_oor_d;
  logic d_err_q, d_err_d;
  logic d_nodata_q, d_nodata_d;

  assign f_oor = addr_oor(f_addr, ADDR_W);
  assign d_oor = addr_oor(d_addr, ADDR_W);

`ifdef IMEM_ARB_WRITE_EN
  assign d_bad     = d_oor;
  assign mem_we    = d_gnt & d_we & ~d_oor;
  assign mem_wdata = d_wdata;
`else
  logic unused_wdata;
  assign unused_wdata = ^d_wdata;
  assign d_bad     = d_oor | d_we;
  assign mem_we    = 1'b0;
  assign mem_wdata = 32'h0;
`endif

  assign d_gnt  = d_req & (~f_req | starve_at_max);
  assign f_gnt  = f_req & ~d_gnt;
  assign f_hold = f_req & ~f_gnt;

  assign mem_en   = (f_gnt & ~f_oor) | (d_gnt & ~d_bad);
  assign mem_addr = d_gnt ? d_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .clr    (d_gnt | ~d_req),
    .inc    (f_gnt & d_req),
    .at_max (starve_at_max)
  );

  always_comb begin
    owner_d    = OWN_NONE;
    f_kill_d   = flush;
    f_oor_d    = f_oor;
    d_err_d    = d_bad;
    d_nodata_d = d_bad | d_we;
    if (d_gnt)
      owner_d = OWN_D;
    else if (f_gnt)
      owner_d = OWN_F;
  end

  // Response-cycle state: who owns the returning mem_rdata and how to qualify it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      f_kill_q   <= 1'b0;
      f_oor_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_nodata_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      f_kill_q   <= f_kill_d;
      f_oor_q    <= f_oor_d;
      d_err_q    <= d_err_d;
      d_nodata_q <= d_nodata_d;
    end
  end

  // A flush in either the grant or the response cycle kills the fetch return.
  assign f_valid = (owner_q == OWN_F) & ~f_kill_q & ~flush;
  assign f_rdata = (f_valid & ~f_oor_q) ? mem_rdata : NOP_INSTR;
  assign d_valid = (owner_q == OWN_D);
  assign d_err   = d_valid & d_err_q;
  assign d_rdata = (d_valid & ~d_nodata_q) ? mem_rdata : 32'h0;

endmodule
